// File: rtl/mcu_ram_sp.sv
// rtl/mcu_ram_sp.sv - parametrised single-port RAM with handshake, collision modes and zero-fill
// Optional per-byte parity storage with perr/pinj ports: define MCU_RAM_PARITY_EN.
module mcu_ram_sp #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 11,
  parameter int OUT_REG        = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                req,
  input  logic                wre,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   ad,
  input  logic [DATA_W-1:0]   din,
  output logic                ready,
  output logic [DATA_W-1:0]   dout,
  output logic                rvalid,
  output logic                busy
`ifdef MCU_RAM_PARITY_EN
  ,
  input  logic [DATA_W/8-1:0] pinj,
  output logic [DATA_W/8-1:0] perr
`endif
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_RST, S_CLEAR, S_IDLE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] fill_ad;
  logic              accept, wr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RST:   state_nx = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      S_CLEAR: if (&fill_ad) state_nx = S_IDLE;
      S_IDLE:  state_nx = S_IDLE;
      default: state_nx = S_RST;
    endcase
  end

  always_comb begin
    ready = (state == S_IDLE);
    busy  = (state == S_CLEAR);
  end

  assign accept = ready & ce & req;
  assign wr_en  = accept & wre;

  // Fill address is zero outside CLEAR so an interrupted fill restarts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     fill_ad <= '0;
    else if (busy) fill_ad <= fill_ad + 1'b1;
    else           fill_ad <= '0;
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] s1_old, s1_din, s1_word;
  logic [NB-1:0]     s1_be;
  logic              s1_v, s1_wr;

  // Read-first array: s1_old captures the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[fill_ad] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++)
        if (be[k]) mem[ad][8*k +: 8] <= din[8*k +: 8];
    end
    s1_old <= mem[ad];
    s1_din <= din;
    s1_be  <= be;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v  <= 1'b0;
      s1_wr <= 1'b0;
    end else begin
      s1_v  <= accept & (~wre | (WRITE_MODE != 0));
      s1_wr <= wre;
    end
  end

  always_comb begin
    s1_word = s1_old;
    if (s1_wr && (WRITE_MODE == 1))
      for (int k = 0; k < NB; k++)
        if (s1_be[k]) s1_word[8*k +: 8] = s1_din[8*k +: 8];
  end

`ifdef MCU_RAM_PARITY_EN
  logic [NB-1:0] mem_p [DEPTH];
  logic [NB-1:0] s1_old_p, s1_pinj, s1_par, s1_perr;

  always_ff @(posedge clk) begin
    if (busy) begin
      mem_p[fill_ad] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++)
        if (be[k]) mem_p[ad][k] <= (^din[8*k +: 8]) ^ pinj[k];
    end
    s1_old_p <= mem_p[ad];
    s1_pinj  <= pinj;
  end

  always_comb begin
    s1_par  = s1_old_p;
    s1_perr = '0;
    if (s1_wr && (WRITE_MODE == 1))
      for (int k = 0; k < NB; k++)
        if (s1_be[k]) s1_par[k] = (^s1_din[8*k +: 8]) ^ s1_pinj[k];
    for (int k = 0; k < NB; k++)
      s1_perr[k] = (^s1_word[8*k +: 8]) ^ s1_par[k];
  end
`endif

  logic              out_v;
  logic [DATA_W-1:0] out_word;
`ifdef MCU_RAM_PARITY_EN
  logic [NB-1:0]     out_perr;
`endif

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              s2_v;
      logic [DATA_W-1:0] s2_word;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s2_v    <= 1'b0;
          s2_word <= '0;
        end else begin
          s2_v    <= s1_v;
          s2_word <= s1_word;
        end
      end
      assign out_v    = s2_v;
      assign out_word = s2_word;
`ifdef MCU_RAM_PARITY_EN
      logic [NB-1:0] s2_perr;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) s2_perr <= '0;
        else       s2_perr <= s1_perr;
      end
      assign out_perr = s2_perr;
`endif
    end else begin : g_noreg
      assign out_v    = s1_v;
      assign out_word = s1_word;
`ifdef MCU_RAM_PARITY_EN
      assign out_perr = s1_perr;
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= 1'b0;
      dout   <= '0;
    end else begin
      rvalid <= out_v;
      if (out_v) dout <= out_word;
    end
  end

`ifdef MCU_RAM_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      perr <= '0;
    else if (out_v) perr <= out_perr;
  end
`endif

endmodule

// File: tb/tb_mcu_ram_sp.sv
// tb/tb_mcu_ram_sp.sv - scoreboard bench for mcu_ram_sp over three latency/collision configurations
module tb_mcu_ram_sp;
  logic        clk = 1'b0;
  logic        reset, ce, req, wre;
  logic [1:0]  be, pinj;
  logic [10:0] ad;
  logic [15:0] din;
  logic [2:0]  ready_o, rvalid_o, busy_o;
  logic [15:0] dout_o [3];
`ifdef MCU_RAM_PARITY_EN
  logic [1:0]  perr_o [3];
`endif

  typedef struct {
    logic [15:0] d;
    logic [1:0]  p;
    int          c;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  // u0: defaults; u1: single-cycle latency, write-through; u2: read-before-write
  mcu_ram_sp #(.OUT_REG(1), .WRITE_MODE(0)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .req(req), .wre(wre), .be(be), .ad(ad), .din(din),
    .ready(ready_o[0]), .dout(dout_o[0]), .rvalid(rvalid_o[0]), .busy(busy_o[0])
`ifdef MCU_RAM_PARITY_EN
    , .pinj(pinj), .perr(perr_o[0])
`endif
  );
  mcu_ram_sp #(.OUT_REG(0), .WRITE_MODE(1)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .req(req), .wre(wre), .be(be), .ad(ad), .din(din),
    .ready(ready_o[1]), .dout(dout_o[1]), .rvalid(rvalid_o[1]), .busy(busy_o[1])
`ifdef MCU_RAM_PARITY_EN
    , .pinj(pinj), .perr(perr_o[1])
`endif
  );
  mcu_ram_sp #(.OUT_REG(1), .WRITE_MODE(2)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .req(req), .wre(wre), .be(be), .ad(ad), .din(din),
    .ready(ready_o[2]), .dout(dout_o[2]), .rvalid(rvalid_o[2]), .busy(busy_o[2])
`ifdef MCU_RAM_PARITY_EN
    , .pinj(pinj), .perr(perr_o[2])
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic push(input int id, input logic [15:0] d, input logic [1:0] p, input int c);
    exp_t e;
    e.d = d; e.p = p; e.c = c;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int id, input logic rv, input logic [15:0] d, input logic [1:0] p);
    exp_t e;
    int   have;
    if (!rv) return;
    n_cmp++;
    case (id)
      0:       have = q0.size();
      1:       have = q1.size();
      default: have = q2.size();
    endcase
    if (have == 0) begin
      n_bad++;
      $display("FAIL unexpected_rvalid u%0d: got dout=%h perr=%b at cycle %0d, required no strobe", id, d, p, cyc);
      return;
    end
    case (id)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    if (d !== e.d || cyc != e.c
`ifdef MCU_RAM_PARITY_EN
        || p !== e.p
`endif
       ) begin
      n_bad++;
      $display("FAIL read_u%0d: got dout=%h perr=%b at cycle %0d, required dout=%h perr=%b at cycle %0d",
               id, d, p, cyc, e.d, e.p, e.c);
    end
  endtask

  always @(negedge clk) begin
`ifdef MCU_RAM_PARITY_EN
    mon(0, rvalid_o[0], dout_o[0], perr_o[0]);
    mon(1, rvalid_o[1], dout_o[1], perr_o[1]);
    mon(2, rvalid_o[2], dout_o[2], perr_o[2]);
`else
    mon(0, rvalid_o[0], dout_o[0], 2'b00);
    mon(1, rvalid_o[1], dout_o[1], 2'b00);
    mon(2, rvalid_o[2], dout_o[2], 2'b00);
`endif
  end

  task automatic drive(input logic c, input logic w, input logic [10:0] a, input logic [15:0] d,
                       input logic [1:0] b, input logic [1:0] pi);
    @(negedge clk);
    ce = c; req = 1'b1; wre = w; ad = a; din = d; be = b; pinj = pi;
  endtask

  // Accept edge is the next posedge (cyc+1); u1 answers one edge later, u0/u2 two.
  task automatic rd(input logic [10:0] a, input logic [15:0] e, input logic [1:0] ep);
    drive(1'b1, 1'b0, a, 16'h0000, 2'b00, 2'b00);
    push(0, e, ep, cyc + 3);
    push(1, e, ep, cyc + 2);
    push(2, e, ep, cyc + 3);
  endtask

  task automatic wr(input logic [10:0] a, input logic [15:0] d, input logic [1:0] b, input logic [1:0] pi,
                    input logic [15:0] e_new, input logic [1:0] p_new,
                    input logic [15:0] e_old, input logic [1:0] p_old);
    drive(1'b1, 1'b1, a, d, b, pi);
    push(1, e_new, p_new, cyc + 2);
    push(2, e_old, p_old, cyc + 3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0; ce = 1'b1; wre = 1'b0; pinj = 2'b00;
    end
  endtask

  task automatic measure_fill(input string nm);
    int n = 0, w = 0;
    while (!busy_o[0] && w < 10) begin @(negedge clk); w++; end
    while (busy_o[0] && !ready_o[0] && n < 3000) begin @(negedge clk); n++; end
    chk({nm, "_len"}, n, 2048);
    chk({nm, "_ready_busy"}, {ready_o, busy_o}, 32'b111000);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, ready_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_rvalid"}, rvalid_o, 0);
    for (int i = 0; i < 3; i++) chk({nm, "_dout"}, dout_o[i], 0);
  endtask

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got no completion by 2 ms, required end of sequence");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    reset = 1'b1; ce = 1'b0; req = 1'b0; wre = 1'b0; be = 2'b00; pinj = 2'b00; ad = '0; din = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b0;
    measure_fill("fill1");

    rd(11'h7FF, 16'h0000, 2'b00);
    wr(11'h005, 16'hABCD, 2'b01, 2'b00, 16'h00CD, 2'b00, 16'h0000, 2'b00);
    rd(11'h005, 16'h00CD, 2'b00);
    wr(11'h010, 16'h1111, 2'b11, 2'b00, 16'h1111, 2'b00, 16'h0000, 2'b00);
    wr(11'h011, 16'h2222, 2'b11, 2'b00, 16'h2222, 2'b00, 16'h0000, 2'b00);
    rd(11'h010, 16'h1111, 2'b00);
    rd(11'h011, 16'h2222, 2'b00);
    wr(11'h020, 16'h1234, 2'b11, 2'b00, 16'h1234, 2'b00, 16'h0000, 2'b00);
    wr(11'h020, 16'hFFFF, 2'b11, 2'b00, 16'hFFFF, 2'b00, 16'h1234, 2'b00);
    rd(11'h020, 16'hFFFF, 2'b00);
    wr(11'h020, 16'h0000, 2'b00, 2'b00, 16'hFFFF, 2'b00, 16'hFFFF, 2'b00);
    rd(11'h020, 16'hFFFF, 2'b00);
    wr(11'h005, 16'h5A00, 2'b10, 2'b00, 16'h5ACD, 2'b00, 16'h00CD, 2'b00);
    rd(11'h005, 16'h5ACD, 2'b00);
    drive(1'b0, 1'b1, 11'h005, 16'hFFFF, 2'b11, 2'b00);
    drive(1'b0, 1'b0, 11'h005, 16'h0000, 2'b00, 2'b00);
    rd(11'h005, 16'h5ACD, 2'b00);
    wr(11'h030, 16'h00FF, 2'b11, 2'b10, 16'h00FF, 2'b10, 16'h0000, 2'b00);
    rd(11'h030, 16'h00FF, 2'b10);
    wr(11'h030, 16'h00FF, 2'b11, 2'b00, 16'h00FF, 2'b00, 16'h00FF, 2'b10);
    rd(11'h030, 16'h00FF, 2'b00);
    idle(6);

    rd(11'h011, 16'h2222, 2'b00);
    @(negedge clk);
    reset = 1'b1; req = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    #1;
    chk_reset_outputs("inflight");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    begin
      int w = 0;
      while (!busy_o[0] && w < 10) begin @(negedge clk); w++; end
    end
    repeat (100) @(negedge clk);
    chk("midfill_busy", busy_o, 3'b111);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midfill");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    measure_fill("fill2");

    rd(11'h005, 16'h0000, 2'b00);
    rd(11'h030, 16'h0000, 2'b00);
    rd(11'h7FF, 16'h0000, 2'b00);
    idle(8);
    chk("drain_u0", q0.size(), 0);
    chk("drain_u1", q1.size(), 0);
    chk("drain_u2", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mcu_ram_sp.md
Name: mcu_ram_sp

Overview:
Parametrised single-port synchronous RAM for MCU program/data storage. Replaces the fixed 16x2048 wrapper with configurable width and depth, per-byte write enables and a request/ready handshake. Adds a read-valid strobe, selectable write-collision modes and an optional output pipeline register. Includes a post-reset zero-fill sequencer. Sits between the MCU core's memory port and the inferred BSRAM.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8.
ADDR_W, 11, address width; DEPTH = 2**ADDR_W words.
OUT_REG, 1, read latency select: 0 = dout one cycle after accept; 1 = extra output register, two cycles.
WRITE_MODE, 0, dout on a write: 0 = normal (dout holds); 1 = write-through (new merged word); 2 = read-before-write (old word).
CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset; 0 = skip the fill.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
ce  in  1  chip enable; when 0, no request is accepted.
req  in  1  access request.
wre  in  1  1 = write, 0 = read.
be  in  DATA_W/8  byte write enables; ignored for reads.
ad  in  ADDR_W  word address.
din  in  DATA_W  write data.
ready  out  1  1 = a request can be accepted this cycle.
dout  out  DATA_W  read or collision data.
rvalid  out  1  one-cycle strobe; dout is valid while it is high.
busy  out  1  high while the zero-fill runs.

Behaviour:
- Reset values: ready=0, rvalid=0, dout=0, busy=0; fill address=0. Array contents are not reset.
- FSM states: RST, CLEAR, IDLE.
  - RST: held while reset=1.
  - On reset release: go to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE.
- CLEAR:
  - busy=1, ready=0.
  - Writes 0 to address 0,1,...,DEPTH-1, one word per clock; be is ignored.
  - Moves to IDLE on the clock after DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles.
  - req is ignored and never queued.
- IDLE: ready=1, busy=0.
- Accept condition: ready & ce & req, sampled at the rising edge. A new request can be accepted every cycle; the pipeline never stalls.
- Read:
  - OUT_REG=0: dout and rvalid update at edge N+1 after the accept edge N.
  - OUT_REG=1: they update at edge N+2.
  - dout holds its last value when rvalid=0.
- Write:
  - Byte k is written only if be[k]=1. be=0 is a legal no-op write.
  - WRITE_MODE 0: no rvalid; dout unchanged.
  - WRITE_MODE 1: dout = stored word after merge (new bytes where be=1, old bytes elsewhere); rvalid asserted with the read latency.
  - WRITE_MODE 2: dout = word before the write; rvalid asserted with the read latency.
- Back-to-back write then read of the same address: the read returns the new data.
- Address wrap: none. ad is exactly ADDR_W bits, so all values are legal.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately (asynchronous).
  - In-flight reads are discarded; no rvalid.
  - A write accepted at the edge before reset completes.
  - A fill interrupted by reset restarts from address 0.
- Pipeline strobes (rvalid stages) are cleared by reset.

Optional Feature:
MCU_RAM_PARITY_EN
- Defined:
  - One even-parity bit is stored per byte, written alongside each enabled byte. The fill stores parity 0.
  - Added output perr[DATA_W/8], aligned with dout/rvalid: bit k=1 if byte k's stored parity mismatches.
  - Added input pinj[DATA_W/8]: inverts the stored parity of byte k when writing with be[k]=1 (test injection).
  - perr resets to 0.
- Undefined: no perr/pinj ports and no parity storage; behaviour is otherwise identical.

Test Plan:
- Defaults, reset pulse 3 cycles -> busy=1 and ready=0 for exactly 2048 cycles; then read 0x7FF -> dout=0x0000, rvalid 2 cycles after accept.
- Write 0x005 din=0xABCD be=2'b01, then read 0x005 -> dout=0x00CD.
- OUT_REG=0: reads of 0x010 and 0x011 on consecutive cycles (preloaded 0x1111, 0x2222) -> dout=0x1111 at N+1, 0x2222 at N+2, rvalid high for both cycles.
- WRITE_MODE=2: addr 0x020 holds 0x1234, write 0xFFFF be=2'b11 -> dout=0x1234 with rvalid; WRITE_MODE=1 repeat -> dout=0xFFFF.
- Assert reset 100 cycles into the fill -> ready=0 immediately; after release the fill restarts at 0 and busy lasts 2048 cycles again.
- MCU_RAM_PARITY_EN: write 0x030 din=0x00FF be=2'b11 pinj=2'b10, read -> dout=0x00FF, perr=2'b10; rewrite with pinj=0, read -> perr=2'b00.
